keypad_code_tx: RTL

//  Transmit side of the safe-lock key-code interface. Scans a 4x4 matrix keypad,

---
 rtl/keypad_code_pkg.sv | 24 ++
 rtl/keypad_frame_scanner.sv | 89 ++++++++
 rtl/keypad_code_tx.sv | 133 +++++++++++++
 3 files changed

// File: rtl/keypad_code_pkg.sv
// Shared definitions for the keypad key-code transmitter.
// Contents: code-bus width, default separator/idle words, FSM state encoding,
// and key2code(), which maps a key index 0..15 to its bus code 1..16.
package keypad_code_pkg;

   localparam int CODE_W = 5;

   localparam logic [CODE_W-1:0] SEP_CODE_DEF  = 5'd21;
   localparam logic [CODE_W-1:0] IDLE_CODE_DEF = 5'd0;

   typedef enum logic [2:0] {
      SCAN,
      DEBNC,
      EMIT_SEP,
      EMIT_KEY,
      WAIT_REL
   } state_t;

   // Codes start at 1 so a key never looks like the idle word (0) and never reaches 21.
   function automatic logic [CODE_W-1:0] key2code(input logic [3:0] k);
      return CODE_W'(k) + CODE_W'(1);
   endfunction

endpackage

// File: rtl/keypad_frame_scanner.sv
// Column scanner and frame decoder for a 4x4 active-low matrix keypad.
// Drives one column low for SCAN_DIV cycles, samples the rows on the last
// dwell cycle, and rotates through columns 0..3. After column 3 it reports
// the frame: exactly one low row bit gives a key index, anything else is NONE.
// Ports:
//   clk, rst     clock, async active-high reset
//   row_in[3:0]  keypad rows, active-low, already synchronised
//   col_out[3:0] column drive, one-cold
//   frame_done   1-cycle pulse when a frame result is valid
//   frame_key    key index row*4+col of the frame (valid when !frame_none)
//   frame_none   frame had zero or several pressed keys
module keypad_frame_scanner #(
   parameter int SCAN_DIV = 1000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] row_in,
   output logic [3:0] col_out,
   output logic       frame_done,
   output logic [3:0] frame_key,
   output logic       frame_none
);

   localparam int              DW_W       = $clog2(SCAN_DIV);
   localparam logic [DW_W-1:0] DWELL_LAST = DW_W'(SCAN_DIV - 1);

   logic [DW_W-1:0] dwell_cnt;
   logic [1:0]      col_idx;
   logic [1:0]      low_acc;   // saturating low-bit count for the frame: 0, 1, 2 (= many)
   logic [3:0]      key_acc;

   logic            sample;
   logic [3:0]      col_lows;
   logic [2:0]      col_n;
   logic [1:0]      col_row;
   logic [2:0]      low_sum;
   logic [1:0]      low_next;
   logic [3:0]      key_next;

   assign sample = (dwell_cnt == DWELL_LAST);

   always_comb begin
      col_lows = ~row_in;
      col_n    = '0;
      col_row  = '0;
      for (int r = 0; r < 4; r++) begin
         if (col_lows[r]) begin
            col_n   = col_n + 3'd1;
            col_row = 2'(r);
         end
      end
      low_sum  = {1'b0, low_acc} + col_n;
      low_next = (low_sum >= 3'd2) ? 2'd2 : low_sum[1:0];
      key_next = (col_n == 3'd1) ? {col_row, col_idx} : key_acc;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dwell_cnt  <= '0;
         col_idx    <= '0;
         col_out    <= 4'b1110;
         low_acc    <= '0;
         key_acc    <= '0;
         frame_done <= 1'b0;
         frame_key  <= '0;
         frame_none <= 1'b0;
      end else begin
         frame_done <= 1'b0;
         if (sample) begin
            dwell_cnt <= '0;
            col_idx   <= col_idx + 2'd1;
            col_out   <= {col_out[2:0], col_out[3]};
            if (col_idx == 2'd3) begin
               frame_done <= 1'b1;
               frame_none <= (low_next != 2'd1);
               frame_key  <= key_next;
               low_acc    <= '0;
               key_acc    <= '0;
            end else begin
               low_acc <= low_next;
               key_acc <= key_next;
            end
         end else begin
            dwell_cnt <= dwell_cnt + DW_W'(1);
         end
      end
   end

endmodule

// File: rtl/keypad_code_tx.sv
// Keypad key-code transmitter: scans the keypad, debounces presses and sends
// each accepted key to the lock as SEP_CODE, key code, then IDLE_CODE.
// A held key is sent once; release must be seen for DEBOUNCE frames.
// Ports:
//   clk, rst        clock, async active-high reset
//   row_in[3:0]     keypad rows, active-low
//   col_out[3:0]    keypad column drive, one-cold
//   code_out[4:0]   registered code bus to the lock
//   busy            high from acceptance until release is confirmed
//   key_strobe      1-cycle pulse alongside the key code
//
// state    | meaning
// ---------+-------------------------------------------------------------
// SCAN     | idle, waiting for a frame with exactly one key
// DEBNC    | candidate key seen, counting consecutive matching frames
// EMIT_SEP | separator word on the bus
// EMIT_KEY | key code on the bus, strobe high
// WAIT_REL | waiting for DEBOUNCE consecutive empty frames
module keypad_code_tx
   import keypad_code_pkg::*;
#(
   parameter int                SCAN_DIV  = 1000,
   parameter int                DEBOUNCE  = 4,
   parameter logic [CODE_W-1:0] SEP_CODE  = SEP_CODE_DEF,
   parameter logic [CODE_W-1:0] IDLE_CODE = IDLE_CODE_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [3:0]        row_in,
   output logic [3:0]        col_out,
   output logic [CODE_W-1:0] code_out,
   output logic              busy,
   output logic              key_strobe
);

   localparam int               CNT_W    = $clog2(DEBOUNCE + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE);

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic [3:0]       cand;

   logic             frame_done;
   logic [3:0]       frame_key;
   logic             frame_none;
   logic             cnt_hit;

   keypad_frame_scanner #(.SCAN_DIV(SCAN_DIV)) u_scanner (
      .clk        (clk),
      .rst        (rst),
      .row_in     (row_in),
      .col_out    (col_out),
      .frame_done (frame_done),
      .frame_key  (frame_key),
      .frame_none (frame_none)
   );

   // The frame being counted now is the one that reaches DEBOUNCE.
   assign cnt_hit = ((cnt + CNT_W'(1)) == CNT_LAST);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= SCAN;
         cnt        <= '0;
         cand       <= '0;
         code_out   <= IDLE_CODE;
         busy       <= 1'b0;
         key_strobe <= 1'b0;
      end else begin
         code_out   <= IDLE_CODE;
         key_strobe <= 1'b0;
         case (state)
            SCAN: begin
               if (frame_done && !frame_none) begin
                  cand <= frame_key;
                  if (DEBOUNCE == 1) begin
                     state    <= EMIT_SEP;
                     code_out <= SEP_CODE;
                     busy     <= 1'b1;
                  end else begin
                     state <= DEBNC;
                     cnt   <= CNT_W'(1);
                  end
               end
            end
            DEBNC: begin
               if (frame_done) begin
                  if (!frame_none && frame_key == cand) begin
                     if (cnt_hit) begin
                        state    <= EMIT_SEP;
                        code_out <= SEP_CODE;
                        busy     <= 1'b1;
                     end else begin
                        cnt <= cnt + CNT_W'(1);
                     end
                  end else begin
                     state <= SCAN;
                  end
               end
            end
            EMIT_SEP: begin
               state      <= EMIT_KEY;
               code_out   <= key2code(cand);
               key_strobe <= 1'b1;
            end
            EMIT_KEY: begin
               state <= WAIT_REL;
               cnt   <= '0;
            end
            WAIT_REL: begin
               if (frame_done) begin
                  if (frame_none) begin
                     if (cnt_hit) begin
                        state <= SCAN;
                        busy  <= 1'b0;
                        cnt   <= '0;
                     end else begin
                        cnt <= cnt + CNT_W'(1);
                     end
                  end else begin
                     cnt <= '0;
                  end
               end
            end
            default: begin
               state <= SCAN;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule
